seven_segment_decoder: RTL and testbench
========================================

Name: seven_segment_decoder

Overview:
Receive-side counterpart of the seven-segment controller. It samples the time-multiplexed, active-low segment and digit enables, filters scan transitions and glitches, and decodes each digit's pattern back to a hex nibble plus decimal-point bit. It assembles a complete frame once every digit has been seen. It is used for loopback self-check on the board and as a bench monitor for the controller.

Parameters:
DIGITS, 4, number of multiplexed digits; width of digitEnableN and pointEnable.
STABLE_CYCLES, 4, consecutive identical samples needed before a digit is captured; minimum 1.
TIMEOUT_WIDTH, 20, width of the idle counter; active drops after 2^TIMEOUT_WIDTH cycles with no capture.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
segmentEnableN  input  8  active-low segments; bit0=a … bit6=g, bit7=dp
digitEnableN  input  DIGITS  active-low digit enables
data  output  4*DIGITS  decoded nibbles; digit i at [4i+3:4i]
pointEnable  output  DIGITS  decoded decimal points
frame_valid  output  1  one-cycle pulse when data/pointEnable update
frame_error  output  1  registered with each frame: 1 if any digit in that frame had an undecodable pattern
pattern_error  output  1  one-cycle pulse on capture of an undecodable pattern
overlap_error  output  1  one-cycle pulse when a multi-hot digit enable has been stable for STABLE_CYCLES
active  output  1  high while a capture occurred within the last 2^TIMEOUT_WIDTH cycles

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: every output and all internal state are 0.
- Reset mid-frame: discards partial frame state. Output data is cleared, not retained.
- Input stage: the inputs are registered once (sample register). The filter uses only sampled values.
- Stability counter:
  - Clears to 0 when the sample differs from the previous sample (either bus).
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture condition: the counter reaches STABLE_CYCLES-1 (a single event per dwell) with the sampled digitEnableN one-hot-low.
  - All-high digitEnableN (blanking) never captures.
  - Multi-hot digitEnableN pulses overlap_error instead of capturing.
- Decode: invert the segments and look up bits[6:0] in the hex table (0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 → 0..F).
  - dp = ~segmentEnableN[7].
  - No table match: nibble = 0, pattern_error pulses, and the staging error bit for that digit is set.
- Staging: per-digit nibble, dp and error registers, plus a seen mask.
  - A capture writes the digit's staging entry and sets its seen bit.
  - Recapturing an already-seen digit overwrites its entry.
- Frame completion: at the capture edge that makes seen all-ones:
  - Staging, including the just-captured digit, is copied to data/pointEnable/frame_error.
  - frame_valid is high for the following cycle.
  - seen clears. Staging error bits clear.
- Latency: a pattern present on the inputs for STABLE_CYCLES+1 consecutive edges is captured on that last edge. Frame outputs are visible after the next edge.
- Between frames, data holds its last value.
- Idle counter: cleared on every capture; otherwise increments, saturating.
  - active = capture seen since reset AND counter not saturated.
- Simultaneous events: a capture and a frame completion on the same edge is the normal case. A reset coinciding with any event wins.

Decomposition:
- Package seven_segment_pkg:
  - hex-to-segment table as a constant array (shared with the encoder).
  - segment bit index constants SEG_A…SEG_G and SEG_DP.
  - function segment_to_hex returning {valid, nibble}.
- One sub-module, seven_segment_stability_filter: the sample register, change detect and saturating counter, emitting a capture strobe and the stable sample. Frame assembly, decode and timeout remain in the top.

Test Plan:
- Scan, value and dp: STABLE_CYCLES=4; controller-style scan, 8-cycle dwell per digit, value 0x12AF, dp on digit 1 → data=0x12AF, pointEnable=4'b0010, frame_error=0, frame_valid once per 32 cycles.
- Glitch rejection: 2-cycle glitch segmentEnableN=8'h00 inside the digit 0 dwell → no extra capture, data unchanged, no pattern_error.
- Undecodable pattern: digit 2 driven with segmentEnableN=8'hFF (blank) for a full dwell → pattern_error pulses once, next frame has frame_error=1 and data[11:8]=0. The following clean frame has frame_error=0.
- Overlap: digitEnableN=4'b1100 held 10 cycles → overlap_error pulses once, no capture, seen unchanged.
- Reset mid-frame: reset asserted one cycle after digits 0 and 1 are captured → all outputs 0; the frame completes only after all four digits are captured again.
- Idle timeout: TIMEOUT_WIDTH=6, scan stopped (digitEnableN=4'hF) → active falls exactly 64 cycles after the last capture. active rises on the first capture after the scan resumes.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: segment bit positions, the hex glyph table and
// the reverse lookup used by the decoder.
package seven_segment_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high glyphs, bit0 = a ... bit6 = g, indexed by nibble value.
  localparam logic [6:0] HEX_TO_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_dec_t;

  // Unknown glyphs return valid = 0 with a zero nibble.
  function automatic hex_dec_t segment_to_hex(input logic [6:0] seg);
    hex_dec_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == HEX_TO_SEG[i]) begin
        res.valid  = 1'b1;
        res.nibble = 4'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seven_segment_stability_filter.sv
// Samples the scan buses once and strobes when the sample has dwelt unchanged long
// enough to be trusted; one strobe per dwell.
module seven_segment_stability_filter #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        segment_n_i,
  input  logic [DIGITS-1:0] digit_n_i,
  output logic [7:0]        segment_n_o,
  output logic [DIGITS-1:0] digit_n_o,
  output logic              stable_o
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntHit = CntW'(STABLE_CYCLES - 1);

  logic [7:0]        seg_q;
  logic [DIGITS-1:0] dig_q;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // The incoming value becomes the new sample on this edge, so comparing it with the
  // current sample is the new-vs-previous sample comparison.
  always_comb begin
    cnt_d = cnt_q;
    if ((segment_n_i != seg_q) || (digit_n_i != dig_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q <= '0;
      dig_q <= '0;
      cnt_q <= '0;
    end else begin
      seg_q <= segment_n_i;
      dig_q <= digit_n_i;
      cnt_q <= cnt_d;
    end
  end

  assign segment_n_o = seg_q;
  assign digit_n_o   = dig_q;
  assign stable_o    = (cnt_q == CntHit);

endmodule

// File: rtl/seven_segment_decoder.sv
// Receive side of the multiplexed seven-segment link: filters the scan, decodes each
// digit back to a nibble + dp and publishes a frame once every digit has been seen.
module seven_segment_decoder
  import seven_segment_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_WIDTH = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            segmentEnableN,
  input  logic [DIGITS-1:0]     digitEnableN,
  output logic [4*DIGITS-1:0]   data,
  output logic [DIGITS-1:0]     pointEnable,
  output logic                  frame_valid,
  output logic                  frame_error,
  output logic                  pattern_error,
  output logic                  overlap_error,
  output logic                  active
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [7:0]        seg_s;
  logic [DIGITS-1:0] dig_s;
  logic              stable;

  seven_segment_stability_filter #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock      (clock),
    .reset      (reset),
    .segment_n_i(segmentEnableN),
    .digit_n_i  (digitEnableN),
    .segment_n_o(seg_s),
    .digit_n_o  (dig_s),
    .stable_o   (stable)
  );

  logic [DIGITS-1:0] dig_on;
  logic              one_hot, multi_hot, capture;
  logic [IdxW-1:0]   idx;
  logic [6:0]        lit;
  hex_dec_t          dec;
  logic              dp;

  always_comb begin
    dig_on    = ~dig_s;
    one_hot   = (dig_on != '0) && ((dig_on & (dig_on - DIGITS'(1))) == '0);
    multi_hot = (dig_on != '0) && !one_hot;
    idx       = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_on[i]) idx = IdxW'(i);
    end
    lit = ~{seg_s[SEG_G], seg_s[SEG_F], seg_s[SEG_E], seg_s[SEG_D],
            seg_s[SEG_C], seg_s[SEG_B], seg_s[SEG_A]};
    dec = segment_to_hex(lit);
    dp  = ~seg_s[SEG_DP];
  end

  assign capture = stable && one_hot;

  logic [4*DIGITS-1:0]    stage_nib_q, stage_nib_d;
  logic [DIGITS-1:0]      stage_dp_q, stage_dp_d;
  logic [DIGITS-1:0]      stage_err_q, stage_err_d;
  logic [DIGITS-1:0]      seen_q, seen_d;
  logic [4*DIGITS-1:0]    data_q, data_d;
  logic [DIGITS-1:0]      point_q, point_d;
  logic                   ferr_q, ferr_d;
  logic                   fvalid_q, fvalid_d;
  logic                   perr_q, perr_d;
  logic                   oerr_q, oerr_d;
  logic [TIMEOUT_WIDTH-1:0] idle_q, idle_d;
  logic                   expired_q, expired_d;
  logic                   ever_q, ever_d;

  always_comb begin
    stage_nib_d = stage_nib_q;
    stage_dp_d  = stage_dp_q;
    stage_err_d = stage_err_q;
    seen_d      = seen_q;
    data_d      = data_q;
    point_d     = point_q;
    ferr_d      = ferr_q;
    fvalid_d    = 1'b0;
    perr_d      = 1'b0;
    oerr_d      = stable && multi_hot;

    if (capture) begin
      stage_nib_d[4*idx +: 4] = dec.valid ? dec.nibble : 4'h0;
      stage_dp_d[idx]         = dp;
      stage_err_d[idx]        = !dec.valid;
      seen_d[idx]             = 1'b1;
      perr_d                  = !dec.valid;
      // The completing digit is folded in via the _d copies before publishing.
      if (&seen_d) begin
        data_d      = stage_nib_d;
        point_d     = stage_dp_d;
        ferr_d      = |stage_err_d;
        fvalid_d    = 1'b1;
        seen_d      = '0;
        stage_err_d = '0;
      end
    end
  end

  // Idle counter saturates at all-ones; the extra expired flag marks the 2^W-th cycle.
  always_comb begin
    idle_d    = idle_q;
    expired_d = expired_q;
    ever_d    = ever_q;
    if (capture) begin
      idle_d    = '0;
      expired_d = 1'b0;
      ever_d    = 1'b1;
    end else if (&idle_q) begin
      expired_d = 1'b1;
    end else begin
      idle_d = idle_q + TIMEOUT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stage_nib_q <= '0;
      stage_dp_q  <= '0;
      stage_err_q <= '0;
      seen_q      <= '0;
      data_q      <= '0;
      point_q     <= '0;
      ferr_q      <= 1'b0;
      fvalid_q    <= 1'b0;
      perr_q      <= 1'b0;
      oerr_q      <= 1'b0;
      idle_q      <= '0;
      expired_q   <= 1'b0;
      ever_q      <= 1'b0;
    end else begin
      stage_nib_q <= stage_nib_d;
      stage_dp_q  <= stage_dp_d;
      stage_err_q <= stage_err_d;
      seen_q      <= seen_d;
      data_q      <= data_d;
      point_q     <= point_d;
      ferr_q      <= ferr_d;
      fvalid_q    <= fvalid_d;
      perr_q      <= perr_d;
      oerr_q      <= oerr_d;
      idle_q      <= idle_d;
      expired_q   <= expired_d;
      ever_q      <= ever_d;
    end
  end

  assign data          = data_q;
  assign pointEnable   = point_q;
  assign frame_valid   = fvalid_q;
  assign frame_error   = ferr_q;
  assign pattern_error = perr_q;
  assign overlap_error = oerr_q;
  assign active        = ever_q && !expired_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: drives controller-style scans and checks published
// frames against an expected-frame queue, plus pulse counts and the idle timeout.
module tb_seven_segment_decoder;

  localparam int unsigned DIGITS        = 4;
  localparam int unsigned STABLE_CYCLES = 4;
  localparam int unsigned TIMEOUT_WIDTH = 6;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  segmentEnableN;
  logic [3:0]  digitEnableN;
  logic [15:0] data;
  logic [3:0]  pointEnable;
  logic        frame_valid, frame_error, pattern_error, overlap_error, active;

  int tests = 0;
  int fails = 0;
  int perr_cnt = 0;
  int oerr_cnt = 0;
  int fv_cnt = 0;
  int cycle = 0;
  int fv_last = 0;
  int fv_prev = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        ferr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  seven_segment_decoder #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT_WIDTH(TIMEOUT_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .segmentEnableN(segmentEnableN),
    .digitEnableN  (digitEnableN),
    .data          (data),
    .pointEnable   (pointEnable),
    .frame_valid   (frame_valid),
    .frame_error   (frame_error),
    .pattern_error (pattern_error),
    .overlap_error (overlap_error),
    .active        (active)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  // Frame scoreboard and pulse counters.
  always @(negedge clock) begin
    if (!reset) begin
      if (pattern_error) perr_cnt++;
      if (overlap_error) oerr_cnt++;
      if (frame_valid) begin
        fv_cnt++;
        fv_prev = fv_last;
        fv_last = cycle;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL frame_unexpected: got data=%h dp=%b with no frame expected",
                   data, pointEnable);
        end else begin
          mon_e = exp_q.pop_front();
          if (data !== mon_e.data) begin
            fails++;
            $display("FAIL frame_data: got %h expected %h", data, mon_e.data);
          end
          tests++;
          if (pointEnable !== mon_e.dp) begin
            fails++;
            $display("FAIL frame_dp: got %b expected %b", pointEnable, mon_e.dp);
          end
          tests++;
          if (frame_error !== mon_e.ferr) begin
            fails++;
            $display("FAIL frame_error: got %b expected %b", frame_error, mon_e.ferr);
          end
        end
      end
    end
  end

  function automatic logic [7:0] enc(input logic [3:0] n, input logic dp);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return ~{dp, s};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [3:0] p, input logic fe);
    exp_t e;
    e.data = d;
    e.dp   = p;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  // 8-cycle dwell per digit; blank_d drives an all-off glyph, glitch_d inserts a
  // 2-cycle all-on glitch after that digit's capture point.
  task automatic scan_digits(input logic [15:0] val, input logic [3:0] dp, input int first,
                             input int last, input int blank_d, input int glitch_d);
    logic [7:0] s;
    for (int d = first; d <= last; d++) begin
      s = (d == blank_d) ? 8'hFF : enc(val[4*d +: 4], dp[d]);
      for (int j = 0; j < 8; j++) begin
        digitEnableN   = ~(4'b0001 << d);
        segmentEnableN = ((d == glitch_d) && (j == 5 || j == 6)) ? 8'h00 : s;
        step();
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    digitEnableN   = 4'hF;
    segmentEnableN = 8'hFF;
    repeat (3) step();
    tests++;
    if ({data, pointEnable} !== 20'h0) begin
      fails++;
      $display("FAIL reset_data: got %h/%b expected 0/0", data, pointEnable);
    end
    tests++;
    if ({frame_valid, frame_error, pattern_error, overlap_error, active} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000",
               {frame_valid, frame_error, pattern_error, overlap_error, active});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_scan();
    int fv0;
    fv0 = fv_cnt;
    repeat (3) begin
      push_exp(16'h12AF, 4'b0010, 1'b0);
      scan_digits(16'h12AF, 4'b0010, 0, 3, -1, -1);
    end
    tests++;
    if (fv_cnt - fv0 !== 3) begin
      fails++;
      $display("FAIL scan_frame_count: got %0d expected 3", fv_cnt - fv0);
    end
    tests++;
    if (fv_last - fv_prev !== 32) begin
      fails++;
      $display("FAIL scan_frame_period: got %0d expected 32", fv_last - fv_prev);
    end
    tests++;
    if (active !== 1'b1) begin
      fails++;
      $display("FAIL scan_active: got %b expected 1", active);
    end
  endtask

  task automatic test_glitch();
    int fv0, p0;
    fv0 = fv_cnt;
    p0  = perr_cnt;
    push_exp(16'h3C5E, 4'b1000, 1'b0);
    scan_digits(16'h3C5E, 4'b1000, 0, 3, -1, 0);
    tests++;
    if (fv_cnt - fv0 !== 1) begin
      fails++;
      $display("FAIL glitch_frame_count: got %0d expected 1", fv_cnt - fv0);
    end
    tests++;
    if (perr_cnt - p0 !== 0) begin
      fails++;
      $display("FAIL glitch_pattern_error: got %0d pulses expected 0", perr_cnt - p0);
    end
  endtask

  task automatic test_pattern();
    int p0;
    p0 = perr_cnt;
    push_exp(16'h9047, 4'b0000, 1'b1);
    scan_digits(16'h9B47, 4'b0100, 0, 3, 2, -1);
    tests++;
    if (perr_cnt - p0 !== 1) begin
      fails++;
      $display("FAIL pattern_error_pulses: got %0d expected 1", perr_cnt - p0);
    end
    push_exp(16'h9B47, 4'b0100, 1'b0);
    scan_digits(16'h9B47, 4'b0100, 0, 3, -1, -1);
    tests++;
    if (frame_error !== 1'b0) begin
      fails++;
      $display("FAIL pattern_clean_frame_error: got %b expected 0", frame_error);
    end
  endtask

  task automatic test_overlap();
    int fv0, o0;
    fv0 = fv_cnt;
    o0  = oerr_cnt;
    scan_digits(16'h0B61, 4'b0101, 0, 1, -1, -1);
    tests++;
    if (data !== 16'h9B47) begin
      fails++;
      $display("FAIL hold_between_frames: got %h expected 9b47", data);
    end
    digitEnableN   = 4'b1100;
    segmentEnableN = enc(4'h5, 1'b0);
    repeat (10) step();
    tests++;
    if (oerr_cnt - o0 !== 1) begin
      fails++;
      $display("FAIL overlap_pulses: got %0d expected 1", oerr_cnt - o0);
    end
    tests++;
    if (fv_cnt - fv0 !== 0) begin
      fails++;
      $display("FAIL overlap_no_frame: got %0d frames expected 0", fv_cnt - fv0);
    end
    push_exp(16'h0B61, 4'b0101, 1'b0);
    scan_digits(16'h0B61, 4'b0101, 2, 3, -1, -1);
    tests++;
    if (fv_cnt - fv0 !== 1) begin
      fails++;
      $display("FAIL overlap_frame_after: got %0d frames expected 1", fv_cnt - fv0);
    end
  endtask

  task automatic test_reset_mid();
    int fv0;
    fv0 = fv_cnt;
    scan_digits(16'h5A3C, 4'b0001, 0, 0, -1, -1);
    digitEnableN   = 4'b1101;
    segmentEnableN = enc(4'h3, 1'b0);
    repeat (5) step();
    reset = 1'b1;
    step();
    tests++;
    if ({data, pointEnable, frame_valid, frame_error, active} !== 23'h0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got data=%h dp=%b fv=%b fe=%b act=%b expected 0",
               data, pointEnable, frame_valid, frame_error, active);
    end
    reset = 1'b0;
    scan_digits(16'h5A3C, 4'b0001, 2, 3, -1, -1);
    tests++;
    if (fv_cnt - fv0 !== 0) begin
      fails++;
      $display("FAIL reset_mid_partial: got %0d frames expected 0", fv_cnt - fv0);
    end
    push_exp(16'h5A3C, 4'b0001, 1'b0);
    scan_digits(16'h5A3C, 4'b0001, 0, 3, -1, -1);
    tests++;
    if (fv_cnt - fv0 !== 1) begin
      fails++;
      $display("FAIL reset_mid_frame: got %0d frames expected 1", fv_cnt - fv0);
    end
  endtask

  task automatic test_idle();
    int first;
    digitEnableN   = 4'b0111;
    segmentEnableN = enc(4'h7, 1'b0);
    repeat (5) step();
    digitEnableN   = 4'hF;
    segmentEnableN = 8'hFF;
    first = -1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (!active) begin
        first = k;
        break;
      end
    end
    tests++;
    if (first !== 64) begin
      fails++;
      $display("FAIL idle_timeout: active fell after %0d cycles expected 64", first);
    end
    digitEnableN   = 4'b1110;
    segmentEnableN = enc(4'h1, 1'b0);
    repeat (4) step();
    tests++;
    if (active !== 1'b0) begin
      fails++;
      $display("FAIL idle_resume_early: got %b expected 0", active);
    end
    step();
    tests++;
    if (active !== 1'b1) begin
      fails++;
      $display("FAIL idle_resume: got %b expected 1", active);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_glitch();
    test_pattern();
    test_overlap();
    test_reset_mid();
    test_idle();
    repeat (2) step();
    tests++;
    if (exp_q.size() !== 0) begin
      fails++;
      $display("FAIL frames_outstanding: got %0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
